data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the CPU data port (mem_addr / mem_write_data / wren -> mem_read_data).
//  Serves a word-addressed data RAM plus a small MMIO window: an LED output register and an
//  8-bit keyboard scancode FIFO filled by the PS/2 front end. Sits between cpu and the board I/O.
// PARAMETERS
//  ADDR_W     10             RAM holds 2**ADDR_W 32-bit words
//  KBD_DEPTH  8              scancode FIFO depth in entries, power of 2, >=2
//  MMIO_BASE  32'hFFFF_0000  base byte address of the MMIO window (64 KiB, aligned)
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst             in   1   reset rst, synchronous, active-high
//  mem_addr        in   32  byte address from CPU; bits [1:0] ignored
//  mem_write_data  in   32  store data
//  wren            in   1   1 = write access this cycle, 0 = read access
//  mem_read_data   out  32  registered read data
//  kbd_valid       in   1   scancode strobe from keyboard front end, 1 cycle per code
//  kbd_code        in   8   scancode, valid when kbd_valid=1
//  kbd_ready       out  1   1 = FIFO not full
//  led_out         out  32  LED register contents
//  kbd_overflow    out  1   sticky: a scancode was dropped because the FIFO was full
// BEHAVIOUR
//  Decode per cycle: mmio_hit = (mem_addr[31:16] == MMIO_BASE[31:16]); else RAM.
//  RAM: index = mem_addr[ADDR_W+1:2]; higher bits below the MMIO window alias.
//   wren=1 -> word written at the rising edge. Contents are not reset.
//   Read latency is 1 cycle: mem_read_data <= word at mem_addr sampled at the edge.
//   Write and read of the same word in one cycle: mem_read_data returns the OLD word (read-first).
//  MMIO map (offset = mem_addr[15:0]):
//   0x0000 LED   R/W; write loads led_out, read returns led_out.
//   0x0004 KSTAT R: {kbd_overflow, zeros, count[$clog2(KBD_DEPTH):0]}; any write clears kbd_overflow.
//   0x0008 KDATA R: {24'b0, head code} and pops; when empty returns 0 and does not pop. Writes ignored.
//   Other offsets: read 0, write ignored. MMIO reads also have 1-cycle latency.
//  Pop rule: CPU holds mem_addr steady across cycles. Pop happens only on the first cycle of a
//   KDATA read run: kd_now = mmio_hit & offset==0x0008 & !wren; pop = kd_now & !kd_prev & !empty;
//   kd_prev <= kd_now every cycle. Returned data is the pre-pop head.
//  FIFO: circular, rd/wr pointers wrap modulo KBD_DEPTH, count 0..KBD_DEPTH; kbd_ready = (count != KBD_DEPTH).
//   push = kbd_valid & (!full | pop). Full with no pop: code dropped, kbd_overflow <= 1.
//   Simultaneous push+pop: both take effect, count unchanged. Empty + push + KDATA read: returns 0, code stored.
//   Overflow set and KSTAT write in the same cycle: set wins.
//  Reset: mem_read_data=0, led_out=0, pointers/count=0, kbd_ready=1, kbd_overflow=0, kd_prev=0.
//   Reset mid-access or with FIFO non-empty discards all FIFO contents; RAM unchanged.
// TESTING
//  1 RAM: write 0x1234_5678 @0x10, read @0x10 -> mem_read_data=0x1234_5678 exactly 1 cycle later.
//  2 Read-first: write 0xAAAA_0000 @0x20 (holding 0x5), read same cycle -> 0x5; next read -> 0xAAAA_0000.
//  3 LED: write 0x0000_00FF @MMIO_BASE -> led_out=0xFF next cycle; read back returns 0xFF.
//  4 FIFO: push 0x1C,0x32; hold KDATA read 5 cycles -> 0x1C, one pop only; re-issue -> 0x32; then 0.
//  5 Overflow: push 9 codes with depth 8 -> kbd_ready=0 after 8th, 9th dropped, KSTAT=0x8000_0008;
//    write KSTAT -> flag clears.
//  6 Full+pop+push same cycle -> count stays 8, order preserved; rst mid-run -> count 0, RAM intact.

Source files
------------

// File: rtl/data_mem_responder.sv
// CPU data-port responder: word RAM plus MMIO LED register and keyboard scancode FIFO.
// Read data is registered (1 cycle); RAM is read-first; kbd_ready drops when the FIFO is full.
module data_mem_responder #(
  parameter int          ADDR_W    = 10,
  parameter int          KBD_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic        wren,
  output logic [31:0] mem_read_data,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_code,
  output logic        kbd_ready,
  output logic [31:0] led_out,
  output logic        kbd_overflow
);

  localparam int PW = $clog2(KBD_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [15:0] OFF_LED   = 16'h0000;
  localparam logic [15:0] OFF_KSTAT = 16'h0004;
  localparam logic [15:0] OFF_KDATA = 16'h0008;

  logic [31:0] ram_q  [2**ADDR_W];
  logic [7:0]  fifo_q [KBD_DEPTH];

  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   led_q;
  logic          ovf_q;
  logic          kd_prev_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          mmio_hit;
  logic [15:0]   offset;
  logic [ADDR_W-1:0] ram_idx;
  logic          kd_now, empty, full, pop, push;
  logic          led_wr, kstat_wr;

  assign mmio_hit = (mem_addr[31:16] == MMIO_BASE[31:16]);
  assign offset   = mem_addr[15:0];
  assign ram_idx  = mem_addr[ADDR_W+1:2];

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(KBD_DEPTH));
  assign kd_now = mmio_hit & (offset == OFF_KDATA) & ~wren;
  // Only the first cycle of a held KDATA read pops, so a stalled CPU sees exactly one dequeue.
  assign pop    = kd_now & ~kd_prev_q & ~empty;
  assign push   = kbd_valid & (~full | pop);

  assign led_wr   = mmio_hit & (offset == OFF_LED) & wren;
  assign kstat_wr = mmio_hit & (offset == OFF_KSTAT) & wren;

  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    rdata_d = ram_q[ram_idx];
    if (mmio_hit) begin
      rdata_d = '0;
      if (!wren) begin
        case (offset)
          OFF_LED:   rdata_d = led_q;
          OFF_KSTAT: rdata_d = {ovf_q, {(31-CW){1'b0}}, cnt_q};
          OFF_KDATA: rdata_d = empty ? 32'h0 : {24'h0, fifo_q[rd_ptr_q]};
          default:   rdata_d = '0;
        endcase
      end
    end
  end

  // Storage arrays carry no reset so they map onto RAM; a reset only discards FIFO pointers.
  always_ff @(posedge clk) begin
    if (!mmio_hit && wren) ram_q[ram_idx] <= mem_write_data;
    if (!rst && push)      fifo_q[wr_ptr_q] <= kbd_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      led_q     <= '0;
      ovf_q     <= 1'b0;
      kd_prev_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rdata_q   <= rdata_d;
      kd_prev_q <= kd_now;
      cnt_q     <= cnt_d;
      if (led_wr) led_q <= mem_write_data;
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      // A dropped code in the same cycle as a clearing write keeps the flag set.
      if (kbd_valid && !push) ovf_q <= 1'b1;
      else if (kstat_wr)      ovf_q <= 1'b0;
    end
  end

  assign mem_read_data = rdata_q;
  assign led_out       = led_q;
  assign kbd_overflow  = ovf_q;
  assign kbd_ready     = ~full;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] KSTAT = BASE + 32'h4;
  localparam logic [31:0] KDATA = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        wren;
  logic [31:0] mem_read_data;
  logic        kbd_valid;
  logic [7:0]  kbd_code;
  logic        kbd_ready;
  logic [31:0] led_out;
  logic        kbd_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .KBD_DEPTH(8), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .wren(wren), .mem_read_data(mem_read_data), .kbd_valid(kbd_valid), .kbd_code(kbd_code),
    .kbd_ready(kbd_ready), .led_out(led_out), .kbd_overflow(kbd_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, clock, then sample point is 1ns after the edge.
  task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic kv = 1'b0, input logic [7:0] kc = 8'h00);
    mem_addr = a; mem_write_data = d; wren = we; kbd_valid = kv; kbd_code = kc;
    @(posedge clk); #1;
    kbd_valid = 1'b0;
  endtask

  logic [7:0] exp_q [$];

  initial begin
    rst = 1'b1; mem_addr = '0; mem_write_data = '0; wren = 1'b0;
    kbd_valid = 1'b0; kbd_code = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", mem_read_data, 32'h0);
    chk("rst_led", led_out, 32'h0);
    chk("rst_ready", {31'h0, kbd_ready}, 32'h1);
    chk("rst_ovf", {31'h0, kbd_overflow}, 32'h0);
    rst = 1'b0;

    // RAM write then read, 1-cycle latency
    acc(32'h10, 32'h1234_5678, 1'b1);
    acc(32'h10, 32'h0, 1'b0);
    chk("ram_rd", mem_read_data, 32'h1234_5678);

    // Read-first on same-word write
    acc(32'h20, 32'h5, 1'b1);
    acc(32'h20, 32'hAAAA_0000, 1'b1);
    chk("ram_rdfirst_old", mem_read_data, 32'h5);
    acc(32'h20, 32'h0, 1'b0);
    chk("ram_rdfirst_new", mem_read_data, 32'hAAAA_0000);

    // LED
    acc(BASE, 32'hFF, 1'b1);
    chk("led_out", led_out, 32'hFF);
    acc(BASE, 32'h0, 1'b0);
    chk("led_rd", mem_read_data, 32'hFF);
    acc(BASE + 32'hC, 32'h0, 1'b0);
    chk("mmio_unmapped", mem_read_data, 32'h0);

    // FIFO: held KDATA read pops once
    acc(32'h0, 32'h0, 1'b0, 1'b1, 8'h1C);
    acc(32'h0, 32'h0, 1'b0, 1'b1, 8'h32);
    acc(KDATA, 32'h0, 1'b0);
    chk("kd_first", mem_read_data, 32'h1C);
    repeat (4) acc(KDATA, 32'h0, 1'b0);
    acc(KSTAT, 32'h0, 1'b0);
    chk("kd_one_pop", mem_read_data, 32'h1);
    acc(KDATA, 32'h0, 1'b0);
    chk("kd_second", mem_read_data, 32'h32);
    acc(BASE, 32'h0, 1'b0);
    acc(KDATA, 32'h0, 1'b0);
    chk("kd_empty", mem_read_data, 32'h0);

    // Empty + push + KDATA read: returns 0, code stored
    acc(BASE, 32'h0, 1'b0);
    acc(KDATA, 32'h0, 1'b0, 1'b1, 8'h55);
    chk("kd_empty_push", mem_read_data, 32'h0);
    acc(BASE, 32'h0, 1'b0);
    acc(KDATA, 32'h0, 1'b0);
    chk("kd_empty_push_stored", mem_read_data, 32'h55);

    // Overflow
    for (int i = 0; i < 8; i++) begin
      chk("ready_before_full", {31'h0, kbd_ready}, 32'h1);
      acc(32'h0, 32'h0, 1'b0, 1'b1, 8'(8'h40 + i));
    end
    chk("ready_full", {31'h0, kbd_ready}, 32'h0);
    acc(32'h0, 32'h0, 1'b0, 1'b1, 8'h99);
    chk("ovf_flag", {31'h0, kbd_overflow}, 32'h1);
    acc(KSTAT, 32'h0, 1'b0);
    chk("kstat_ovf", mem_read_data, 32'h8000_0008);
    acc(KSTAT, 32'h0, 1'b1, 1'b1, 8'h99);
    chk("ovf_set_wins", {31'h0, kbd_overflow}, 32'h1);
    acc(KSTAT, 32'h0, 1'b1);
    acc(KSTAT, 32'h0, 1'b0);
    chk("kstat_cleared", mem_read_data, 32'h0000_0008);

    // Full + pop + push same cycle
    acc(KDATA, 32'h0, 1'b0, 1'b1, 8'hAA);
    chk("full_pop_push_rd", mem_read_data, 32'h40);
    acc(KSTAT, 32'h0, 1'b0);
    chk("full_pop_push_cnt", mem_read_data, 32'h8);
    for (int i = 1; i < 8; i++) exp_q.push_back(8'(8'h40 + i));
    exp_q.push_back(8'hAA);
    foreach (exp_q[i]) begin
      acc(KDATA, 32'h0, 1'b0);
      chk($sformatf("order_%0d", i), mem_read_data, {24'h0, exp_q[i]});
      acc(KSTAT, 32'h0, 1'b0);
    end
    chk("drained_cnt", mem_read_data, 32'h0);

    // Reset mid-run discards FIFO, keeps RAM
    acc(32'h0, 32'h0, 1'b0, 1'b1, 8'h77);
    rst = 1'b1;
    acc(KDATA, 32'h0, 1'b0, 1'b1, 8'h78);
    rst = 1'b0;
    chk("rst_mid_rdata", mem_read_data, 32'h0);
    acc(KSTAT, 32'h0, 1'b0);
    chk("rst_mid_cnt", mem_read_data, 32'h0);
    chk("rst_mid_led", led_out, 32'h0);
    acc(32'h10, 32'h0, 1'b0);
    chk("rst_ram_kept", mem_read_data, 32'h1234_5678);
    acc(32'h1010, 32'h0, 1'b0);
    chk("ram_alias", mem_read_data, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
